maze_carver_dfs: RTL
====================

// Module: maze_carver_dfs
// PURPOSE
//  Parametrised depth-first (recursive-backtracker) maze generator for a W x H tile grid.
//  Cells sit on even (x,y) tiles; odd tiles are walls between cells; carving one step opens
//  both the wall tile and the target cell tile. Carving uses an explicit on-chip stack and
//  an internal seeded LFSR. Adds a run/pause control and a carved-cell counter.
//  Output map feeds the maze renderer/player logic as a flat tile bitmap (1=path, 0=wall).
// PARAMETERS
//  W            16      grid width in tiles, >=3
//  H            16      grid height in tiles, >=3
//  Derived: XW=$clog2(W), YW=$clog2(H), NC=((W+1)/2)*((H+1)/2) cells,
//           SD=NC stack depth, CW=$clog2(NC+1)
// PORTS
//  clk           in   1       clock, all logic on posedge
//  rst           in   1       synchronous active-high reset
//  start         in   1       begin new maze; sampled only in IDLE or DONE
//  run           in   1       1=advance carving; 0=freeze all state (pause)
//  seed          in   16      LFSR seed, latched on accepted start
//  start_x       in   XW      start tile x, latched on accepted start
//  start_y       in   YW      start tile y, latched on accepted start
//  maze_data     out  W*H     tile map, bit index x + y*W, 1=path
//  busy          out  1       high in CARVE
//  done          out  1       high in DONE until next accepted start or rst
//  cells_carved  out  CW      cells opened in current maze, incl. start cell
// BEHAVIOUR
//  Reset: state=IDLE, maze_data=0, busy=0, done=0, cells_carved=0, stack ptr sp=0, LFSR=16'hACE1.
//  States: IDLE -> CARVE -> DONE; DONE -> CARVE on start. start while CARVE is ignored.
//  Accepted start (IDLE/DONE, start=1), one cycle:
//   - sx=start_x with LSB forced 0, forced to 0 if >=W; same rule for sy vs H.
//   - maze_data cleared, then bit (sx,sy) set; cur=(sx,sy); sp=0; cells_carved=1.
//   - LFSR <= seed, or 16'hACE1 if seed==0. done=0, busy=1, state=CARVE. run ignored here.
//  CARVE, each cycle with run=1 (run=0: nothing changes, LFSR included):
//   - LFSR steps once, taps x^16+x^14+x^13+x^11; r=LFSR[1:0] from the pre-step value.
//   - Dirs 0=up(y-2) 1=right(x+2) 2=down(y+2) 3=left(x-2).
//   - Candidate d valid iff target in 0..W-1 / 0..H-1 and target tile bit==0.
//   - Pick first valid of r, r+1, r+2, r+3 (mod 4).
//   - Valid pick: set wall tile (midpoint) and target tile; stack[sp]=cur; sp+1;
//     cur=target; cells_carved+1.
//   - No valid pick, sp>0: cur=stack[sp-1]; sp-1 (pop, no map change).
//   - No valid pick, sp==0: state=DONE, busy=0, done=1.
//  Timing: with run held 1, CARVE lasts exactly 2*(NC-1)+1 cycles (each cell pushed once,
//   popped once, plus the final empty check).
//  Result: spanning tree; exactly NC cells + (NC-1) walls set, i.e. 2*NC-1 ones. Odd/odd
//   tiles never set; for even W, column W-1 is never set (same for even H, row H-1).
//  Stack never exceeds NC-1 entries; no overflow path.
//  rst mid-CARVE aborts immediately to reset values; partial map is discarded.
//  Identical seed/start_x/start_y gives an identical maze_data, independent of pause pattern.
// TESTING
//  rst, W=H=16, start(seed=1,x=4,y=4), run=1 -> busy 127 cycles, done=1, cells_carved=64,
//   popcount(maze_data)=127, bit(4+4*16)=1, column 15 all 0.
//  W=H=3, start(seed=16'h1234,x=0,y=0) -> done after 7 CARVE cycles, popcount=7,
//   bit 4 (tile 1,1) = 0, bits 0,2,6,8 = 1.
//  Same seed twice, second run with run toggled 1/0 every 3 cycles -> identical maze_data,
//   done latency = 127 active cycles.
//  start_x=5, start_y=17 (W=H=16) -> start cell (4,0): bit 4 set 1 cycle after start.
//  rst asserted at CARVE cycle 40 -> next cycle: maze_data=0, busy=0, done=0,
//   cells_carved=0; start pulse during CARVE -> no effect on map or latency.
//  seed=0 vs seed=16'hACE1 -> identical maze_data; start from DONE -> regenerates, done
//   drops for 127 cycles.

Source files
------------

// File: rtl/maze_carver_dfs.sv
// maze_carver_dfs: depth-first (recursive-backtracker) maze generator.
// Cells live on even (x,y) tiles. Carving a step opens the wall tile between the
// current cell and an unvisited neighbour, plus the neighbour itself. Backtracking
// uses an on-chip stack of cell coordinates. Direction choice comes from a
// 16-bit Fibonacci LFSR.
//
// Handshake: start is a level sampled only in IDLE or DONE. There it is accepted
// on the first rising clock edge where it is high. While CARVE is active, start
// is ignored. run gates every CARVE step (pause), and busy/done are decoded from
// the state register.
module maze_carver_dfs #(
  parameter  int W  = 16,
  parameter  int H  = 16,
  localparam int XW = $clog2(W),
  localparam int YW = $clog2(H),
  localparam int NC = ((W + 1) / 2) * ((H + 1) / 2),
  localparam int CW = $clog2(NC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic [15:0]       seed,
  input  logic [XW-1:0]     start_x,
  input  logic [YW-1:0]     start_y,
  output logic [W*H-1:0]    maze_data,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     cells_carved
);

  localparam int SD  = NC;
  localparam int SPW = $clog2(SD);
  localparam int IW  = $clog2(W * H);

  localparam logic [XW:0] WL    = (XW + 1)'(W);
  localparam logic [YW:0] HL    = (YW + 1)'(H);
  localparam logic [XW:0] ONE_X = (XW + 1)'(1);
  localparam logic [XW:0] TWO_X = (XW + 1)'(2);
  localparam logic [YW:0] ONE_Y = (YW + 1)'(1);
  localparam logic [YW:0] TWO_Y = (YW + 1)'(2);
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CARVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W*H-1:0]       maze_q, maze_d;
  logic [XW-1:0]        cur_x_q, cur_x_d;
  logic [YW-1:0]        cur_y_q, cur_y_d;
  logic [SPW-1:0]       sp_q, sp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [XW+YW-1:0]     stack_q [SD];
  logic                 push;
  logic [XW+YW-1:0]     pop_entry;

  // Neighbour candidates, one per direction: 0=up 1=right 2=down 3=left.
  logic [XW:0]          cxe, sx_e;
  logic [YW:0]          cye, sy_e;
  logic [XW:0]          tx [4];
  logic [XW:0]          mx [4];
  logic [YW:0]          ty [4];
  logic [YW:0]          my [4];
  logic                 inb [4];
  logic                 ok [4];
  logic                 found;
  logic [1:0]           pick;
  logic [1:0]           dk;

  // Flat tile index: bit x + y*W.
  function automatic logic [IW-1:0] tile_idx(input logic [XW:0] x, input logic [YW:0] y);
    return IW'(y) * IW'(W) + IW'(x);
  endfunction

  // Fibonacci LFSR, x^16+x^14+x^13+x^11, shifting right (feedback enters bit 15).
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  assign cxe       = {1'b0, cur_x_q};
  assign cye       = {1'b0, cur_y_q};
  assign pop_entry = stack_q[sp_q - 1'b1];

  // Neighbour targets, wall midpoints and whether each move is legal.
  always_comb begin
    tx[0] = cxe;          ty[0] = cye - TWO_Y;  mx[0] = cxe;          my[0] = cye - ONE_Y;
    tx[1] = cxe + TWO_X;  ty[1] = cye;          mx[1] = cxe + ONE_X;  my[1] = cye;
    tx[2] = cxe;          ty[2] = cye + TWO_Y;  mx[2] = cxe;          my[2] = cye + ONE_Y;
    tx[3] = cxe - TWO_X;  ty[3] = cye;          mx[3] = cxe - ONE_X;  my[3] = cye;
    inb[0] = (cye >= TWO_Y);
    inb[1] = ((cxe + TWO_X) < WL);
    inb[2] = ((cye + TWO_Y) < HL);
    inb[3] = (cxe >= TWO_X);
    for (int d = 0; d < 4; d++) begin
      ok[d] = inb[d] && !maze_q[tile_idx(tx[d], ty[d])];
    end
  end

  // First legal direction in the rotation r, r+1, r+2, r+3 with r = LFSR[1:0].
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    dk    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      dk = lfsr_q[1:0] + 2'(k);
      if (!found && ok[dk]) begin
        found = 1'b1;
        pick  = dk;
      end
    end
  end

  // Start coordinates: force even, fall back to 0 when off the grid.
  always_comb begin
    sx_e = {1'b0, start_x} & {{XW{1'b1}}, 1'b0};
    sy_e = {1'b0, start_y} & {{YW{1'b1}}, 1'b0};
    if (sx_e >= WL) sx_e = '0;
    if (sy_e >= HL) sy_e = '0;
  end

  // Next-state logic: accept start, carve, backtrack or finish.
  always_comb begin
    state_d = state_q;
    maze_d  = maze_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          maze_d = '0;
          maze_d[tile_idx(sx_e, sy_e)] = 1'b1;
          cur_x_d = sx_e[XW-1:0];
          cur_y_d = sy_e[YW-1:0];
          sp_d    = '0;
          cnt_d   = CW'(1);
          lfsr_d  = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
          state_d = S_CARVE;
        end
      end
      S_CARVE: begin
        if (run) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (found) begin
            maze_d[tile_idx(mx[pick], my[pick])] = 1'b1;
            maze_d[tile_idx(tx[pick], ty[pick])] = 1'b1;
            push    = 1'b1;
            sp_d    = sp_q + 1'b1;
            cur_x_d = tx[pick][XW-1:0];
            cur_y_d = ty[pick][YW-1:0];
            cnt_d   = cnt_q + 1'b1;
          end else if (sp_q != '0) begin
            cur_x_d = pop_entry[XW-1:0];
            cur_y_d = pop_entry[XW+YW-1:XW];
            sp_d    = sp_q - 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      maze_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_DEFAULT;
    end else begin
      state_q <= state_d;
      maze_q  <= maze_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Backtrack stack: push the cell being left; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_q[sp_q] <= {cur_y_q, cur_x_q};
    end
  end

  assign maze_data    = maze_q;
  assign busy         = (state_q == S_CARVE);
  assign done         = (state_q == S_DONE);
  assign cells_carved = cnt_q;

endmodule
